// File: rtl/frame_axis_packer.sv
// Packs a stream of 8-bit pixels into 32-bit AXI-Stream beats, lane 0 first,
// with a partial last beat and tlast on the final pixel of each frame.
module frame_axis_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_frame_done
);

  localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

  logic [CNT_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic [1:0]       lane_reg, lane_next;
  logic [31:0]      acc_reg, acc_next;
  logic [31:0]      beat_data;
  logic [3:0]       beat_keep;
  logic [31:0]      tdata_reg;
  logic [3:0]       tkeep_reg;
  logic             tlast_reg;
  logic             tvalid_reg;
  logic             frame_done_reg;

  logic last_pix;
  logic closing;
  logic ready;
  logic in_xfer;
  logic out_xfer;

  assign last_pix = (pix_cnt_reg == LAST_IDX);
  assign closing  = (lane_reg == 2'd3) || last_pix;
  // A closing pixel needs the output slot to be free (or freeing this cycle).
  assign ready    = !i_rst && (!closing || !tvalid_reg || i_tready);
  assign in_xfer  = i_data_valid && ready;
  assign out_xfer = tvalid_reg && i_tready;

  // Beat as it would look with the current pixel merged into its lane;
  // lanes above the current one are still zero from the last clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign beat_data[8*gi +: 8] = (lane_reg == 2'(gi)) ? i_data : acc_reg[8*gi +: 8];
      assign beat_keep[gi]        = (2'(gi) <= lane_reg);
    end
  endgenerate

  always_comb begin
    pix_cnt_next = pix_cnt_reg;
    lane_next    = lane_reg;
    acc_next     = acc_reg;
    if (in_xfer) begin
      pix_cnt_next = last_pix ? '0 : pix_cnt_reg + CNT_W'(1);
      if (closing) begin
        lane_next = 2'd0;
        acc_next  = '0;
      end else begin
        lane_next = lane_reg + 2'd1;
        acc_next  = beat_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt_reg    <= '0;
      lane_reg       <= '0;
      acc_reg        <= '0;
      tdata_reg      <= '0;
      tkeep_reg      <= '0;
      tlast_reg      <= 1'b0;
      tvalid_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      pix_cnt_reg    <= pix_cnt_next;
      lane_reg       <= lane_next;
      acc_reg        <= acc_next;
      frame_done_reg <= out_xfer && tlast_reg;
      if (in_xfer && closing) begin
        tdata_reg  <= beat_data;
        tkeep_reg  <= beat_keep;
        tlast_reg  <= last_pix;
        tvalid_reg <= 1'b1;
      end else if (out_xfer) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign o_data_ready = ready;
  assign o_tdata      = tdata_reg;
  assign o_tkeep      = tkeep_reg;
  assign o_tlast      = tlast_reg;
  assign o_tvalid     = tvalid_reg;
  assign o_frame_done = frame_done_reg;

endmodule

// File: tb/tb_frame_axis_packer.sv
// Bench for frame_axis_packer: a 4x3 instance driven by directed and random
// streams against a beat-queue model, plus a 5x1 instance for the partial beat.
module tb_frame_axis_packer;

  localparam int PIX_A = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4x3 instance
  logic        a_rst = 1'b1;
  logic [7:0]  a_data = '0;
  logic        a_dv = 1'b0;
  logic        a_tready = 1'b0;
  logic        a_ready;
  logic [31:0] a_tdata;
  logic [3:0]  a_tkeep;
  logic        a_tlast;
  logic        a_tvalid;
  logic        a_done;

  frame_axis_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_data(a_data), .i_data_valid(a_dv),
    .o_data_ready(a_ready), .o_tdata(a_tdata), .o_tkeep(a_tkeep),
    .o_tlast(a_tlast), .o_tvalid(a_tvalid), .i_tready(a_tready),
    .o_frame_done(a_done)
  );

  // 5x1 instance
  logic        b_rst = 1'b1;
  logic [7:0]  b_data = '0;
  logic        b_dv = 1'b0;
  logic        b_tready = 1'b1;
  logic        b_ready;
  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep;
  logic        b_tlast;
  logic        b_tvalid;
  logic        b_done;

  frame_axis_packer #(.IMG_WIDTH(5), .IMG_HEIGHT(1)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_data(b_data), .i_data_valid(b_dv),
    .o_data_ready(b_ready), .o_tdata(b_tdata), .o_tkeep(b_tkeep),
    .o_tlast(b_tlast), .o_tvalid(b_tvalid), .i_tready(b_tready),
    .o_frame_done(b_done)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position of the next pixel, bytes gathered for the
  // current beat, and closed beats not yet taken by the sink.
  int          pos = 0;
  logic [31:0] acc_d = '0;
  logic [3:0]  acc_k = '0;
  beat_t       exp_q[$];
  bit          done_exp = 1'b0;
  int          beats_out = 0;
  int          tlast_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    pos = 0;
    acc_d = '0;
    acc_k = '0;
    exp_q.delete();
    done_exp = 1'b0;
  endtask

  // One clock of dut_a: drive, check, then advance the model by the handshakes.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, output bit accepted);
    bit closes, exp_valid, in_x, out_x;
    @(negedge clk);
    a_dv = v;
    a_data = d;
    a_tready = rdy;
    #1;
    exp_valid = (exp_q.size() != 0);
    closes = ((pos % 4) == 3) || (pos == PIX_A - 1);
    chk("tvalid", 32'(a_tvalid), 32'(exp_valid));
    if (a_tvalid && exp_valid) begin
      chk("tdata", a_tdata, exp_q[0].d);
      chk("tkeep", 32'(a_tkeep), 32'(exp_q[0].k));
      chk("tlast", 32'(a_tlast), 32'(exp_q[0].l));
    end
    chk("frame_done", 32'(a_done), 32'(done_exp));
    chk("data_ready", 32'(a_ready), 32'(!closes || !exp_valid || rdy));
    in_x = v && a_ready;
    out_x = a_tvalid && rdy;
    done_exp = 1'b0;
    if (out_x) begin
      beats_out++;
      if (a_tlast) tlast_seen++;
      if (exp_valid) begin
        done_exp = exp_q[0].l;
        void'(exp_q.pop_front());
      end
    end
    if (in_x) begin
      acc_d[8*(pos%4) +: 8] = d;
      acc_k[pos%4] = 1'b1;
      if (closes) begin
        exp_q.push_back('{d: acc_d, k: acc_k, l: (pos == PIX_A - 1)});
        acc_d = '0;
        acc_k = '0;
      end
      pos = (pos + 1) % PIX_A;
    end
    accepted = in_x;
  endtask

  task automatic reset_a();
    @(negedge clk);
    a_rst = 1'b1;
    a_dv = 1'b0;
    #1;
    chk("ready_in_reset", 32'(a_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_tlast", 32'(a_tlast), 32'd0);
    chk("rst_tkeep", 32'(a_tkeep), 32'd0);
    chk("rst_tdata", a_tdata, 32'd0);
    chk("rst_frame_done", 32'(a_done), 32'd0);
    a_rst = 1'b0;
    model_clear();
  endtask

  task automatic stream(input int n, input logic [7:0] base, input int vpct, input int rpct);
    int idx = 0;
    int guard = 0;
    bit a;
    while (idx < n && guard < 4000) begin
      cycle(($urandom % 100) < vpct, base + 8'(idx), ($urandom % 100) < rpct, a);
      if (a) idx++;
      guard++;
    end
    chk("stream_complete", 32'(idx), 32'(n));
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, a);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit a;
    int t0;
    int idx;
    int stall;
    int nb;
    logic [31:0] bd[2];
    logic [3:0]  bk[2];
    logic        bl[2];

    // Partial-beat frame on the 5x1 instance.
    @(negedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b_dv = (i < 5);
      b_data = 8'hA0 + 8'(i);
      #1;
      if (b_tvalid && b_tready) begin
        if (nb < 2) begin
          bd[nb] = b_tdata;
          bk[nb] = b_tkeep;
          bl[nb] = b_tlast;
        end
        nb++;
      end
    end
    b_dv = 1'b0;
    chk("b_beats", 32'(nb), 32'd2);
    chk("b_beat1_data", bd[0], 32'hA3A2A1A0);
    chk("b_beat1_keep", 32'(bk[0]), 32'hF);
    chk("b_beat1_last", 32'(bl[0]), 32'd0);
    chk("b_beat2_data", bd[1], 32'h000000A4);
    chk("b_beat2_keep", 32'(bk[1]), 32'h1);
    chk("b_beat2_last", 32'(bl[1]), 32'd1);

    // Basic frame 0x01..0x0C with the sink always ready.
    reset_a();
    t0 = tlast_seen;
    stream(12, 8'h01, 100, 100);
    drain();
    chk("single_frame_tlast", 32'(tlast_seen - t0), 32'd1);
    $display("frame 0x01..0x0C streamed, beats so far %0d", beats_out);

    // Sink stalls for 10 cycles while the first beat is on offer.
    t0 = beats_out;
    idx = 0;
    stall = 0;
    for (int c = 0; c < 100 && idx < 12; c++) begin
      bit rdy;
      rdy = !(exp_q.size() != 0 && beats_out == t0 && stall < 10);
      if (!rdy) stall++;
      cycle(1'b1, 8'h01 + 8'(idx), rdy, a);
      if (a) idx++;
    end
    chk("stall_stream_complete", 32'(idx), 32'd12);
    drain();
    chk("stall_beats", 32'(beats_out - t0), 32'd3);
    $display("stalled frame delivered, beats so far %0d", beats_out);

    // Two frames back to back.
    t0 = tlast_seen;
    stream(24, 8'h40, 100, 100);
    drain();
    chk("b2b_tlast", 32'(tlast_seen - t0), 32'd2);
    $display("two back-to-back frames streamed, beats so far %0d", beats_out);

    // Four frames with random valid and ready.
    t0 = tlast_seen;
    stream(48, 8'h80, 50, 50);
    drain();
    chk("random_tlast", 32'(tlast_seen - t0), 32'd4);
    $display("four random frames streamed, beats so far %0d", beats_out);

    // Reset in the middle of a frame, then a fresh frame.
    stream(6, 8'hC0, 100, 0);
    reset_a();
    t0 = tlast_seen;
    stream(12, 8'hD0, 100, 100);
    drain();
    chk("post_reset_tlast", 32'(tlast_seen - t0), 32'd1);
    $display("post-reset frame streamed, beats so far %0d", beats_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_axis_packer.md
FRAME_AXIS_PACKER -- requirements
Module: frame_axis_packer

Interface
REQ-001 Parameter IMG_WIDTH, default 512, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 512, lines per frame.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_data  input  8  processed pixel from the edge-tracking output FIFO.
REQ-006 i_data_valid  input  1  i_data valid.
REQ-007 o_data_ready  output  1  block accepts i_data this cycle.
REQ-008 o_tdata  output  32  packed pixels; pixel n of a beat in bits [8n+7:8n].
REQ-009 o_tkeep  output  4  byte-valid mask for o_tdata.
REQ-010 o_tlast  output  1  final beat of the frame.
REQ-011 o_tvalid  output  1  output beat valid.
REQ-012 i_tready  input  1  downstream DMA accepts the beat.
REQ-013 o_frame_done  output  1  one-cycle pulse when the tlast beat is accepted.

Function
REQ-014 Input transfer occurs when i_data_valid and o_data_ready are both 1; output transfer occurs when o_tvalid and i_tready are both 1.
REQ-015 PIXELS = IMG_WIDTH*IMG_HEIGHT; pixel counter width = clog2(PIXELS); counter holds index of next pixel in frame, range 0..PIXELS-1.
REQ-016 Lane counter 0..3 selects the byte lane written by each accepted pixel; lanes fill 0,1,2,3 in order.
REQ-017 A beat closes when lane 3 is written or when the pixel at index PIXELS-1 is written.
REQ-018 On close, accumulator content shall load into the output register on the next edge: o_tvalid=1, o_tkeep = one bit set per written lane (1111 full, 0001/0011/0111 partial), unwritten lanes = 0x00.
REQ-019 o_tlast = 1 only on the beat containing pixel PIXELS-1.
REQ-020 Latency: o_tvalid rises exactly one cycle after the closing input transfer.
REQ-021 o_data_ready = 1 when the accepted pixel would not close a beat; otherwise o_data_ready = (!o_tvalid || i_tready).
REQ-022 Simultaneous closing input transfer and output transfer: output register reloads with the new beat; o_tvalid stays 1; no bubble, no loss.
REQ-023 Output transfer with no closing input: o_tvalid clears next cycle.
REQ-024 While o_tvalid=1 and i_tready=0, o_tdata/o_tkeep/o_tlast shall remain stable.
REQ-025 After pixel PIXELS-1 is accepted, pixel and lane counters wrap to 0; next pixel starts a new frame in lane 0.
REQ-026 o_frame_done = 1 for exactly the cycle after the tlast beat transfers; otherwise 0.
REQ-027 i_data_valid=0 for any number of cycles shall not change counters or accumulator.

Reset
REQ-028 While i_rst=1 at a clock edge: o_tvalid=0, o_tlast=0, o_tkeep=0000, o_tdata=0, o_frame_done=0, pixel and lane counters=0, accumulator=0.
REQ-029 o_data_ready shall be 0 during the reset cycle and evaluate per REQ-021 from the first cycle with i_rst=0.
REQ-030 Reset mid-frame discards any partial beat and pending output beat; the first pixel after reset is index 0.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3 unless noted)
REQ-031 Stream bytes 0x01..0x0C, i_tready=1 -> beats 0x04030201, 0x08070605, 0x0C0B0A09; tkeep=1111; tlast on beat 3 only; o_frame_done pulse one cycle after beat 3.
REQ-032 IMG_WIDTH=5, IMG_HEIGHT=1, bytes 0xA0..0xA4 -> beat 1 0xA3A2A1A0 tkeep=1111 tlast=0; beat 2 0x000000A4 tkeep=0001 tlast=1.
REQ-033 i_tready=0 for 10 cycles after beat 1 -> o_data_ready drops at lane 3 of beat 2; beat 1 held stable; release -> all 12 bytes delivered in order, none lost or duplicated.
REQ-034 Two frames back-to-back, i_tready=1 -> 6 beats; tlast on beats 3 and 6; o_frame_done pulses twice; second frame starts in lane 0.
REQ-035 Random i_data_valid and i_tready (50%), 4 frames -> output byte stream equals input byte stream; tlast count = 4.
REQ-036 Assert i_rst after 6 bytes -> next cycle all outputs at reset values; then 12 fresh bytes -> 3 correct beats with tlast on beat 3.
